// File: rtl/dly_tap_pkg.sv
// rtl/dly_tap_pkg.sv - shared state type and saturating tap step for the delay tap bank
package dly_tap_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } dly_state_t;

    // Widest tap register the step helper supports; callers pass their real width.
    localparam int DLY_TAP_W_MAX = 16;

    function automatic logic [DLY_TAP_W_MAX-1:0] dly_sat_step(
        input logic [DLY_TAP_W_MAX-1:0] value,
        input logic                     incdec,
        input int                       tap_w
    );
        logic [DLY_TAP_W_MAX-1:0] top_val;
        top_val = DLY_TAP_W_MAX'((32'd1 << tap_w) - 32'd1);
        if (incdec) begin
            return (value == top_val) ? value : value + DLY_TAP_W_MAX'(1);
        end
        return (value == '0) ? value : value - DLY_TAP_W_MAX'(1);
    endfunction

endpackage

// File: rtl/dly_settle_timer.sv
// rtl/dly_settle_timer.sv - settle window down-counter with busy level and done pulse
module dly_settle_timer
    import dly_tap_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    dly_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                        cnt   <= CNT_W'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    // done lands in the first IDLE cycle, alongside busy dropping
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SETTLE);

endmodule

// File: rtl/dly_tap_bank.sv
// rtl/dly_tap_bank.sv - per-channel delay tap registers with load/step, settle handshake and readback
module dly_tap_bank
    import dly_tap_pkg::*;
#(
    parameter int NUM_CH     = 20,
    parameter int TAP_W      = 6,
    parameter int ADDR_W     = 5,
    parameter int SETTLE_CYC = 4,
    parameter int INIT_TAP   = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDR_W-1:0]       DLY_ADDR,
    input  logic                    DLY_LOAD,
    input  logic [TAP_W-1:0]        DLY_LOAD_VAL,
    input  logic                    DLY_ADJ,
    input  logic                    DLY_INCDEC,
    output logic                    DLY_BUSY,
    output logic                    DLY_DONE,
    output logic                    DLY_ERR,
    output logic [TAP_W-1:0]        DLY_TAP_VALUE,
    output logic [NUM_CH*TAP_W-1:0] DLY_TAP_BUS
);

    logic [TAP_W-1:0] taps [NUM_CH];
    logic [TAP_W-1:0] sel_tap;
    logic [TAP_W-1:0] new_tap;
    logic [TAP_W-1:0] tap_value_q;
    logic             err_q;
    logic             busy;
    logic             cmd;
    logic             addr_ok;
    logic             accept;

    always_comb begin
        sel_tap = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (DLY_ADDR == ADDR_W'(k)) begin
                sel_tap = taps[k];
            end
        end
    end

    assign addr_ok = ({1'b0, DLY_ADDR} < (ADDR_W + 1)'(NUM_CH));
    assign cmd     = DLY_LOAD | DLY_ADJ;
    assign accept  = !busy && cmd && addr_ok;

    // LOAD outranks ADJ when both are asserted
    always_comb begin
        new_tap = sel_tap;
        if (DLY_LOAD) begin
            new_tap = DLY_LOAD_VAL;
        end else begin
            new_tap = TAP_W'(dly_sat_step(DLY_TAP_W_MAX'(sel_tap), DLY_INCDEC, TAP_W));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                taps[k] <= TAP_W'(INIT_TAP);
            end
            tap_value_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= !busy && cmd && !addr_ok;
            for (int k = 0; k < NUM_CH; k++) begin
                if (accept && (DLY_ADDR == ADDR_W'(k))) begin
                    taps[k] <= new_tap;
                end
            end
            // readback shows the post-edge value, so a same-cycle update is visible at once
            if (!addr_ok) begin
                tap_value_q <= '0;
            end else if (accept) begin
                tap_value_q <= new_tap;
            end else begin
                tap_value_q <= sel_tap;
            end
        end
    end

    dly_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .CLK  (CLK),
        .RST  (RST),
        .start(accept),
        .busy (busy),
        .done (DLY_DONE)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_bus
        assign DLY_TAP_BUS[k*TAP_W +: TAP_W] = taps[k];
    end

    assign DLY_BUSY      = busy;
    assign DLY_ERR       = err_q;
    assign DLY_TAP_VALUE = tap_value_q;

endmodule
